// File: rtl/conv_pkg.sv
// Shared types and constants for the conv engine and its result reader.
package conv_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2,
    RD_FIN   = 2'd3
  } rd_state_e;

  localparam int unsigned DSIZE_DEF = 256;
  localparam int unsigned RES_W     = 32;

  // One extra address bit, matching the conv engine's mo port.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/conv_rd_fifo2.sv
// Two-entry FIFO holding a result word plus its row/frame tags.
module conv_rd_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         eol_i,
  input  logic         last_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         eol_o,
  output logic         last_o,
  output logic [1:0]   count_o
);

  logic [W+1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok;
  logic         pop_ok;
  logic [W+1:0] head;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= {last_i, eol_i, data_i};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Outputs are forced to zero when empty so stale entries never leak out.
  assign head    = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign data_o  = valid_o ? head[W-1:0] : '0;
  assign eol_o   = valid_o & head[W];
  assign last_o  = valid_o & head[W+1];
  assign count_o = count_q;

endmodule

// File: rtl/conv_result_reader.sv
// Walks the conv result buffer after completion and streams it out with row/frame markers.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned AW    = calc_aw(DSIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [7:0]       out_width_i,
  input  logic [7:0]       out_height_i,
  input  logic [AW-1:0]    base_addr_i,
  output logic [AW-1:0]    mo_addr_o,
  output logic             mo_rd_o,
  input  logic [RES_W-1:0] mo_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [RES_W-1:0] m_data_o,
  output logic             m_eol_o,
  output logic             m_last_o,
  output logic             busy_o,
  output logic             done_o
);

  rd_state_e     state_q, state_d;
  logic [7:0]    width_q, width_d;
  logic [7:0]    height_q, height_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    row_q, row_d;
  logic [AW-1:0] base_q, base_d;
  logic [15:0]   total_q, total_d;
  logic [15:0]   idx_q, idx_d;
  logic          inflight_q;
  logic          eol_p_q, last_p_q;

  logic             f_valid, f_eol, f_last;
  logic [RES_W-1:0] f_data;
  logic [1:0]       f_count;
  logic             pop;
  logic [2:0]       occ;
  logic             issue;
  logic             eol_tag, last_tag;

  assign pop = f_valid & m_ready_i;

  // A slot freed by this cycle's pop counts as free, which keeps a stream with
  // m_ready held high bubble-free while never exceeding two outstanding reads.
  assign occ   = {1'b0, f_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == RD_RUN) && (idx_q < total_q) && (occ < 3'd2);

  assign eol_tag  = (col_q == width_q - 8'd1);
  assign last_tag = eol_tag && (row_q == height_q - 8'd1);

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    base_d   = base_q;
    total_d  = total_q;
    idx_d    = idx_q;
    col_d    = col_q;
    row_d    = row_q;
    unique case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          if ((out_width_i != 8'd0) && (out_height_i != 8'd0)) begin
            width_d  = out_width_i;
            height_d = out_height_i;
            base_d   = base_addr_i;
            total_d  = {8'd0, out_width_i} * {8'd0, out_height_i};
            idx_d    = 16'd0;
            col_d    = 8'd0;
            row_d    = 8'd0;
            state_d  = RD_RUN;
          end else begin
            state_d = RD_FIN;
          end
        end
      end
      RD_RUN: begin
        if (issue) begin
          idx_d = idx_q + 16'd1;
          col_d = eol_tag ? 8'd0 : col_q + 8'd1;
          row_d = eol_tag ? row_q + 8'd1 : row_q;
          if (idx_q == total_q - 16'd1) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (pop && f_last) state_d = RD_FIN;
      end
      RD_FIN:  state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RD_IDLE;
      width_q    <= 8'd0;
      height_q   <= 8'd0;
      base_q     <= '0;
      total_q    <= 16'd0;
      idx_q      <= 16'd0;
      col_q      <= 8'd0;
      row_q      <= 8'd0;
      inflight_q <= 1'b0;
      eol_p_q    <= 1'b0;
      last_p_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      base_q     <= base_d;
      total_q    <= total_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= issue;
      eol_p_q    <= issue & eol_tag;
      last_p_q   <= issue & last_tag;
    end
  end

  conv_rd_fifo2 #(
    .W (RES_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (mo_data_i),
    .eol_i   (eol_p_q),
    .last_i  (last_p_q),
    .pop_i   (pop),
    .valid_o (f_valid),
    .data_o  (f_data),
    .eol_o   (f_eol),
    .last_o  (f_last),
    .count_o (f_count)
  );

  assign mo_rd_o   = issue;
  assign mo_addr_o = issue ? (base_q + idx_q[AW-1:0]) : '0;
  assign m_valid_o = f_valid;
  assign m_data_o  = f_data;
  assign m_eol_o   = f_eol;
  assign m_last_o  = f_last;
  assign busy_o    = (state_q == RD_RUN) || (state_q == RD_DRAIN);
  assign done_o    = (state_q == RD_FIN);

endmodule
